// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared state encoding and constants for sram_ctrl
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SRAM_DW             = 16;
    localparam int DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - 32-bit load/store to 16-bit async SRAM in two halfword phases
// Optional SRAM_CTRL_STATS_EN adds a saturating stall_count output.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [SRAM_DW-1:0] sram_dq_i,
    output logic [SRAM_DW-1:0] sram_dq_o,
    output logic               sram_dq_oe,
    output logic               sram_we_n
`ifdef SRAM_CTRL_STATS_EN
    ,
    output logic [31:0]        stall_count
`endif
);

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t              state;
    state_t              state_nx;
    logic [3:0]          cnt;
    logic                op_wr;
    logic [SRAM_AW-2:0]  addr_q;
    logic [SRAM_DW-1:0]  wdata_hi;
    logic                req;
    logic                phase_end;
    logic                unused_addr_bits;

    assign req              = wr_en | rd_en;
    assign phase_end        = (cnt == LAST);
    assign unused_addr_bits = ^{address[31:SRAM_AW+1], address[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req)       state_nx = LO;
            LO:      if (phase_end) state_nx = HI;
            HI:      if (phase_end) state_nx = DONE;
            DONE:                   state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready      = 1'b0;
        sram_dq_oe = 1'b0;
        sram_we_n  = 1'b1;
        unique case (state)
            IDLE:    ready = ~req;
            LO, HI: begin
                sram_dq_oe = op_wr;
                sram_we_n  = ~op_wr;
            end
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Address and write data are presented from the first cycle of each phase,
    // so they are loaded on the edge that enters the phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            op_wr     <= 1'b0;
            addr_q    <= '0;
            wdata_hi  <= '0;
            rdata     <= '0;
            sram_addr <= '0;
            sram_dq_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        op_wr     <= wr_en;
                        addr_q    <= address[SRAM_AW:2];
                        wdata_hi  <= wdata[31:16];
                        sram_addr <= {address[SRAM_AW:2], 1'b0};
                        if (wr_en) sram_dq_o <= wdata[15:0];
                    end
                end
                LO: begin
                    if (phase_end) begin
                        cnt       <= '0;
                        sram_addr <= {addr_q, 1'b1};
                        if (op_wr) sram_dq_o    <= wdata_hi;
                        else       rdata[15:0]  <= sram_dq_i;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HI: begin
                    if (phase_end) begin
                        cnt <= '0;
                        if (!op_wr) rdata[31:16] <= sram_dq_i;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE:    cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

`ifdef SRAM_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               stall_count <= '0;
        else if (!ready && stall_count != '1)   stall_count <= stall_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - randomized bench for sram_ctrl with a transaction-timeline reference model
module tb_sram_ctrl;

    localparam int W  = 2;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en;
    logic [31:0]   address, wdata;
    logic [31:0]   rdata;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_i, sram_dq_o;
    logic          sram_dq_oe, sram_we_n;
`ifdef SRAM_CTRL_STATS_EN
    logic [31:0]   stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    sram_ctrl #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
`ifdef SRAM_CTRL_STATS_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_init(input int i);
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // SRAM device model: writes land while we_n is low, reads are combinational.
    logic [15:0] sram_mem [0:2047];
    logic        sram_init_done = 1'b0;
    always @(posedge clk) begin
        if (!sram_init_done) begin
            for (int i = 0; i < 2048; i++) sram_mem[i] <= mem_init(i);
            sram_init_done <= 1'b1;
        end else if (!sram_we_n) begin
            sram_mem[sram_addr[10:0]] <= sram_dq_o;
        end
    end
    assign sram_dq_i = sram_mem[sram_addr[10:0]];

    // Reference model: k is the cycle index within the current access
    // (request seen in IDLE is cycle 0, LO = 1..W, HI = W+1..2W, DONE = 2W+1).
    logic [15:0] model_mem [0:2047];
    logic        m_init = 1'b0;
    int          k = -1;
    logic        m_wr;
    logic [16:0] m_a;
    logic [31:0] m_d;
    logic [31:0] e_rdata = '0;
    logic [17:0] e_addr  = '0;
    logic [15:0] e_dq    = '0;
    logic [31:0] e_stall = '0;
    logic        e_ready, e_act, e_oe, m_req, m_hi;

    always @(negedge clk) begin
        if (!m_init) begin
            for (int i = 0; i < 2048; i++) model_mem[i] = mem_init(i);
            m_init = 1'b1;
        end
        if (!rst) begin
            k = -1; e_rdata = '0; e_addr = '0; e_dq = '0; e_stall = '0;
        end
        m_req = wr_en | rd_en;
        e_act = 1'b0;
        if (k < 0) begin
            e_ready = !m_req;
        end else if (k <= 2 * W) begin
            e_ready = 1'b0;
            e_act   = 1'b1;
            m_hi    = (k > W);
            e_addr  = {m_a, m_hi};
            if (m_wr) e_dq = m_hi ? m_d[31:16] : m_d[15:0];
        end else begin
            e_ready = 1'b1;
        end
        e_oe = e_act && m_wr;

        chk("ready", 32'(ready), 32'(e_ready));
        chk("rdata", rdata, e_rdata);
        chk("sram_addr", 32'(sram_addr), 32'(e_addr));
        chk("sram_dq_oe", 32'(sram_dq_oe), 32'(e_oe));
        chk("sram_we_n", 32'(sram_we_n), 32'(!e_oe));
        if (e_oe) chk("sram_dq_o", 32'(sram_dq_o), 32'(e_dq));
`ifdef SRAM_CTRL_STATS_EN
        chk("stall_count", stall_count, e_stall);
`endif

        if (rst) begin
            if (!e_ready && e_stall != 32'hFFFF_FFFF) e_stall = e_stall + 1;
            if (k < 0) begin
                if (m_req) begin
                    k = 1; m_wr = wr_en; m_a = address[18:2]; m_d = wdata;
                end
            end else if (k == 2 * W + 1) begin
                k = -1;
                if (m_wr) begin
                    model_mem[{m_a[9:0], 1'b0}] = m_d[15:0];
                    model_mem[{m_a[9:0], 1'b1}] = m_d[31:16];
                end
            end else begin
                if (!m_wr && k == W)     e_rdata[15:0]  = model_mem[{m_a[9:0], 1'b0}];
                if (!m_wr && k == 2 * W) e_rdata[31:16] = model_mem[{m_a[9:0], 1'b1}];
                k++;
            end
        end
    end

    // Issue one request (or an idle cycle when both enables are low), holding it
    // until ready; address/wdata are scrambled mid-access. Starts and ends at posedge+1.
    task automatic txn(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        int n;
        wr_en = w; rd_en = r; address = a; wdata = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready) break;
            n++;
            if (n > 4 * W + 8) begin
                checks++; failures++;
                $display("FAIL txn_timeout actual=ready_low_%0d_cycles expected=ready", n);
                break;
            end
            @(posedge clk); #1;
            address = $urandom; wdata = $urandom;
        end
        @(posedge clk); #1;
    endtask

    task automatic go_idle();
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_o", 32'(sram_dq_o), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_we_n", 32'(sram_we_n), 32'd1);
        end
        @(posedge clk); #1;

        // Store 0xDEADBEEF to 0x408: halfwords at 0x204 then 0x205.
        wr_en = 1'b1; address = 32'h0000_0408; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("st_ready_c0", 32'(ready), 32'd0);
        for (int i = 1; i <= 2 * W; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("st_addr", 32'(sram_addr), (i <= W) ? 32'h204 : 32'h205);
            chk("st_dq_o", 32'(sram_dq_o), (i <= W) ? 32'hBEEF : 32'hDEAD);
            chk("st_we_n", 32'(sram_we_n), 32'd0);
            chk("st_ready", 32'(ready), 32'd0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("st_ready_done", 32'(ready), 32'd1);
        @(posedge clk); #1;
        go_idle();
        @(negedge clk);
        @(posedge clk); #1;

        txn(1'b0, 1'b1, 32'h0000_0408, 32'h0);
        go_idle();
        @(negedge clk);
        chk("ld_rdata_held", rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Both enables: write wins, rdata untouched.
        txn(1'b1, 1'b1, 32'h0000_0810, 32'h1234_5678);
        go_idle();
        @(negedge clk);
        chk("both_rdata_kept", rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        txn(1'b0, 1'b1, 32'h0000_0810, 32'h0);
        go_idle();
        @(negedge clk);
        chk("both_wrote", rdata, 32'h1234_5678);
        @(posedge clk); #1;

        // Reset during HI of a load.
        rd_en = 1'b1; address = 32'h0000_0408;
        repeat (W + 1) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("pre_rst_ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_we_n", 32'(sram_we_n), 32'd1);
        chk("midrst_ready", 32'(ready), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 1'b1, 32'h0000_0408, 32'h0);
        go_idle();
        @(negedge clk);
        chk("post_rst_load", rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Randomized traffic; consecutive requests run back-to-back.
        for (int t = 0; t < 300; t++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 7);
            a    = ($urandom & 32'hFFF8_0000) | ($urandom & 32'h0000_0FFF);
            case (kind)
                0, 1, 2: txn(1'b1, 1'b0, a, $urandom);
                3, 4, 5: txn(1'b0, 1'b1, a, $urandom);
                6:       txn(1'b1, 1'b1, a, $urandom);
                default: txn(1'b0, 1'b0, a, $urandom);
            endcase
        end
        go_idle();
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
